// File: rtl/synapse_weight_sequencer.sv
// Feeds one LIF neuron: scans an accepted spike vector in ascending index order, fetches the weight
// of each active synapse from a sync-read memory and strobes it into the neuron; counts spikes per window.
module synapse_weight_sequencer #(
    parameter int NUM_INPUTS   = 16,
    parameter int WEIGHT_WIDTH = 8,
    parameter int ADDR_W       = $clog2(NUM_INPUTS),
    parameter int CNT_W        = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    spk_valid,
    output logic                    spk_ready,
    input  logic [NUM_INPUTS-1:0]   spk_vec,
    input  logic                    last_step,
    output logic                    w_ren,
    output logic [ADDR_W-1:0]       w_addr,
    input  logic [WEIGHT_WIDTH-1:0] w_rdata,
    output logic [WEIGHT_WIDTH-1:0] data_in,
    output logic                    clken,
    output logic                    clr,
    input  logic                    spike_out,
    output logic                    step_done,
    output logic [CNT_W-1:0]        win_cnt,
    output logic                    win_valid
);

    typedef enum logic [2:0] {IDLE, SCAN, DRAIN, CLEAR, DONE} state_t;

    state_t                  state;
    logic [NUM_INPUTS-1:0]   vec_p0;
    logic                    last_p0;
    logic                    vld_p1;
    logic                    clr_p1;
    logic [CNT_W-1:0]        cnt;
    logic [ADDR_W-1:0]       nxt_addr;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        if (inc && (v == {CNT_W{1'b1}}))
            return v;
        else
            return v + CNT_W'(inc);
    endfunction

    assign nxt_addr  = w_addr + ADDR_W'(1);
    assign spk_ready = (state == IDLE) && !rst;
    // Reset must clear the neuron and cancel any in-flight strobe in the same cycle it is seen.
    assign clken     = vld_p1 && !rst;
    assign data_in   = clken ? w_rdata : '0;
    assign clr       = clr_p1 || rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            w_ren     <= 1'b0;
            w_addr    <= '0;
            vld_p1    <= 1'b0;
            clr_p1    <= 1'b0;
            step_done <= 1'b0;
            win_valid <= 1'b0;
            win_cnt   <= '0;
            cnt       <= '0;
        end else begin
            // p0 -> p1: a read issued now returns its weight next cycle
            vld_p1    <= w_ren;
            step_done <= 1'b0;
            clr_p1    <= 1'b0;
            win_valid <= 1'b0;
            cnt       <= sat_inc(cnt, spike_out);
            case (state)
                IDLE: begin
                    if (spk_valid) begin
                        vec_p0  <= spk_vec;
                        last_p0 <= last_step;
                        w_addr  <= '0;
                        w_ren   <= spk_vec[0];
                        state   <= SCAN;
                    end
                end
                SCAN: begin
                    if (w_addr == ADDR_W'(NUM_INPUTS - 1)) begin
                        w_ren <= 1'b0;
                        state <= DRAIN;
                    end else begin
                        w_addr <= nxt_addr;
                        w_ren  <= vec_p0[nxt_addr];
                    end
                end
                DRAIN: begin
                    step_done <= 1'b1;
                    clr_p1    <= last_p0;
                    win_valid <= last_p0;
                    state     <= last_p0 ? CLEAR : DONE;
                end
                CLEAR: begin
                    // A spike landing in the clear cycle belongs to the window being closed.
                    win_cnt <= sat_inc(cnt, spike_out);
                    cnt     <= '0;
                    state   <= IDLE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
